qqspi_arbiter: RTL and testbench

//  Two-master arbiter in front of the single qqspi controller (NOR flash + 2x PSRAM banks).

---
 rtl/qqspi_arb_pkg.sv | 26 ++
 rtl/qqspi_arbiter_rr2.sv | 22 ++
 rtl/qqspi_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_qqspi_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qqspi_arb_pkg.sv
// Shared types and constants for the two-master qqspi arbiter.
// Holds the FSM state encoding, master indices and the round-robin pick rule.
package qqspi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CS_NOR      = 0;
  localparam int CS_PSRAM_LO = 1;
  localparam int CS_PSRAM_HI = 2;

  // Winner index: sole requester, or the master that did not win last time.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/qqspi_arbiter_rr2.sv
// Combinational 2-way round-robin picker: one-hot grant plus an any-request flag.
import qqspi_arb_pkg::*;

module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       any
);

  logic winner;

  always_comb begin
    winner = rr_pick(req, last);
    any    = |req;
    gnt    = 2'b00;
    if (any) begin
      gnt[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/qqspi_arbiter.sv
// Two-master arbiter in front of the qqspi controller: IDLE/BUSY/DRAIN FSM with a registered payload.
// Optional performance counters are built when QQSPI_ARB_PERF_EN is defined.
import qqspi_arb_pkg::*;

module qqspi_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int CS_WIDTH   = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  input  logic                  m0_psram,
  input  logic [CS_WIDTH-1:0]   m0_ce_ctrl,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  input  logic                  m1_psram,
  input  logic [CS_WIDTH-1:0]   m1_ce_ctrl,
  output logic [31:0]           m1_rdata,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  output logic                  s_psram,
  output logic [CS_WIDTH-1:0]   s_ce_ctrl,
  input  logic [31:0]           s_rdata,
  input  logic                  perf_clr,
  output logic [CNT_WIDTH-1:0]  perf_m0_cnt,
  output logic [CNT_WIDTH-1:0]  perf_m1_cnt,
  output logic [CNT_WIDTH-1:0]  perf_wait_cnt
);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  s_valid_q, s_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  psram_q, psram_d;
  logic [CS_WIDTH-1:0]   ce_q, ce_d;

  logic [1:0] gnt;
  logic       any_req;
  logic       done;

  arb_rr2 u_rr (
    .req  ({m1_valid, m0_valid}),
    .last (last_q),
    .gnt  (gnt),
    .any  (any_req)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    s_valid_d = s_valid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    psram_d   = psram_q;
    ce_d      = ce_q;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d   = gnt[1];
          last_d    = gnt[1];
          s_valid_d = 1'b1;
          state_d   = ST_BUSY;
          if (gnt[1]) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            wstrb_d = m1_wstrb;
            psram_d = m1_psram;
            ce_d    = m1_ce_ctrl;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            wstrb_d = m0_wstrb;
            psram_d = m0_psram;
            ce_d    = m0_ce_ctrl;
          end
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          done      = 1'b1;
          s_valid_d = 1'b0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Owner drops its valid here; waiting master is picked up next IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= M0;
      last_q    <= M1;
      s_valid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      psram_q   <= 1'b0;
      ce_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      s_valid_q <= s_valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      psram_q   <= psram_d;
      ce_q      <= ce_d;
    end
  end

  // Completion is returned combinationally, only to the owner.
  assign m0_ready  = done && (owner_q == M0);
  assign m1_ready  = done && (owner_q == M1);
  assign m0_rdata  = m0_ready ? s_rdata : '0;
  assign m1_rdata  = m1_ready ? s_rdata : '0;

  assign s_valid   = s_valid_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign s_psram   = psram_q;
  assign s_ce_ctrl = ce_q;

`ifdef QQSPI_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] m0_cnt_q, m0_cnt_d;
  logic [CNT_WIDTH-1:0] m1_cnt_q, m1_cnt_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                 wait_hit;

  always_comb begin
    wait_hit   = (state_q != ST_IDLE) && ((owner_q == M0) ? m1_valid : m0_valid);
    m0_cnt_d   = m0_cnt_q;
    m1_cnt_d   = m1_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (perf_clr) begin
      m0_cnt_d   = '0;
      m1_cnt_d   = '0;
      wait_cnt_d = '0;
    end else begin
      if (m0_ready && (m0_cnt_q != '1)) m0_cnt_d = m0_cnt_q + CNT_WIDTH'(1);
      if (m1_ready && (m1_cnt_q != '1)) m1_cnt_d = m1_cnt_q + CNT_WIDTH'(1);
      if (wait_hit && (wait_cnt_q != '1)) wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_cnt_q   <= '0;
      m1_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      m0_cnt_q   <= m0_cnt_d;
      m1_cnt_q   <= m1_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign perf_m0_cnt   = m0_cnt_q;
  assign perf_m1_cnt   = m1_cnt_q;
  assign perf_wait_cnt = wait_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_m0_cnt     = '0;
  assign perf_m1_cnt     = '0;
  assign perf_wait_cnt   = '0;
`endif

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Scoreboard bench for qqspi_arbiter: random two-master traffic against a round-robin reference model.
`timescale 1ns/1ps
module tb_qqspi_arbiter;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        psram;
    logic [2:0]  ce;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_t        cur [2];
  logic [1:0]  m_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready, s_psram;
  logic [22:0] s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_ce_ctrl;
  logic        perf_clr;
  logic [31:0] perf_m0_cnt, perf_m1_cnt, perf_wait_cnt;
  logic        auto_ready, man_ready;
  logic [31:0] auto_rdata, man_rdata;
  logic        slave_en;

  assign s_ready = auto_ready | man_ready;
  assign s_rdata = auto_ready ? auto_rdata : man_rdata;

  qqspi_arbiter #(.ADDR_WIDTH(23), .CS_WIDTH(3), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m_valid[0]), .m0_ready(m0_ready), .m0_addr(cur[0].addr), .m0_wdata(cur[0].wdata),
    .m0_wstrb(cur[0].wstrb), .m0_psram(cur[0].psram), .m0_ce_ctrl(cur[0].ce), .m0_rdata(m0_rdata),
    .m1_valid(m_valid[1]), .m1_ready(m1_ready), .m1_addr(cur[1].addr), .m1_wdata(cur[1].wdata),
    .m1_wstrb(cur[1].wstrb), .m1_psram(cur[1].psram), .m1_ce_ctrl(cur[1].ce), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_psram(s_psram), .s_ce_ctrl(s_ce_ctrl), .s_rdata(s_rdata),
    .perf_clr(perf_clr), .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt),
    .perf_wait_cnt(perf_wait_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  int          grant_q[$];
  logic [31:0] rdata_q[$];
  int          grant_log[$];
  int          last_winner = 1;
  int          owner = 0;
  logic [1:0]  prev_valid = 2'b00;
  logic        prev_s_valid = 1'b0;
  logic        drain = 1'b0;
  logic        was_drain;
  int          w_new, w_done;
  logic [31:0] d_done;
  int          exp_cnt [2];
  int          exp_wait = 0;

  always @(negedge clk) begin
    if (rst) begin
      grant_q.delete();
      rdata_q.delete();
      last_winner  = 1;
      owner        = 0;
      prev_valid   = 2'b00;
      prev_s_valid = 1'b0;
      drain        = 1'b0;
      exp_cnt[0]   = 0;
      exp_cnt[1]   = 0;
      exp_wait     = 0;
    end else begin
      was_drain = drain;
      drain     = 1'b0;
      // A new grant was decided in the previous cycle from the requests seen then.
      if (s_valid && !prev_s_valid) begin
        check("grant_had_request", {63'd0, prev_valid != 2'b00}, 64'd1);
        if (prev_valid == 2'b11) w_new = 1 - last_winner;
        else if (prev_valid[1])  w_new = 1;
        else                     w_new = 0;
        grant_q.push_back(w_new);
        grant_log.push_back(w_new);
        last_winner = w_new;
        owner       = w_new;
      end
      if (s_valid) begin
        check("s_payload", {1'b0, s_addr, s_wdata, s_wstrb, s_psram, s_ce_ctrl}, {1'b0, cur[owner]});
      end
      if (m0_ready || m1_ready) begin
        if (grant_q.size() == 0 || rdata_q.size() == 0) begin
          check("spurious_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
        end else begin
          w_done = grant_q.pop_front();
          d_done = rdata_q.pop_front();
          check("ready_owner", {62'd0, m1_ready, m0_ready}, (w_done == 1) ? 64'd2 : 64'd1);
          check("rdata_owner", (w_done == 1) ? m1_rdata : m0_rdata, d_done);
          check("rdata_other", (w_done == 1) ? m0_rdata : m1_rdata, 64'd0);
          $display("txn m%0d addr=0x%06h wstrb=%b ce=%b rdata=0x%08h", w_done, s_addr, s_wstrb, s_ce_ctrl, d_done);
          exp_cnt[w_done]++;
          drain = 1'b1;
        end
      end
      if ((s_valid || was_drain) && ((owner == 1) ? m_valid[0] : m_valid[1])) exp_wait++;
      if (perf_clr) begin
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        exp_wait   = 0;
      end
      prev_valid   = m_valid;
      prev_s_valid = s_valid;
    end
  end

  // qqspi responder: completes each transaction 1..4 cycles into BUSY with random data.
  int dly = 1;
  initial begin
    auto_ready = 1'b0;
    auto_rdata = '0;
    forever begin
      @(posedge clk); #1;
      auto_ready = 1'b0;
      auto_rdata = '0;
      if (slave_en && s_valid && !rst) begin
        if (dly == 0) begin
          auto_ready = 1'b1;
          auto_rdata = $urandom;
          rdata_q.push_back(auto_rdata);
          dly = $urandom_range(1, 4);
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic rdy(input int m);
    return (m == 1) ? m1_ready : m0_ready;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.addr  = 23'($urandom);
    r.wdata = $urandom;
    r.wstrb = 4'($urandom);
    r.psram = 1'($urandom);
    r.ce    = 3'b001 << $urandom_range(0, 2);
    return r;
  endfunction

  task automatic master(input int m, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      if (i >= 8) begin
        repeat ($urandom_range(0, 3)) cyc();
      end
      cur[m]     = rand_req();
      m_valid[m] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!rdy(m) && t < 200);
      check("ready_timeout", {63'd0, rdy(m)}, 64'd1);
      cyc();
      m_valid[m] = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; m_valid = 2'b00; perf_clr = 1'b0; slave_en = 1'b0;
    man_ready = 1'b0; man_rdata = '0;
    cur[0] = '0; cur[1] = '0;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_s_valid", {63'd0, s_valid}, 64'd0);
    check("rst_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
    check("rst_payload", {1'b0, s_addr, s_wdata, s_wstrb, s_psram, s_ce_ctrl}, 64'd0);
    check("rst_perf", {perf_m0_cnt, perf_m1_cnt | perf_wait_cnt}, 64'd0);
    cyc();
    rst = 1'b0;

    // Directed m0 read, response driven by hand
    cyc();
    cur[0] = '{addr: 23'h000100, wdata: 32'h0, wstrb: 4'h0, psram: 1'b0, ce: 3'b001};
    m_valid[0] = 1'b1;
    @(negedge clk);
    check("req_s_valid_lat0", {63'd0, s_valid}, 64'd0);
    cyc();
    man_ready = 1'b1; man_rdata = 32'hDEADBEEF;
    rdata_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("req_s_valid_lat1", {63'd0, s_valid}, 64'd1);
    check("req_s_addr", {41'd0, s_addr}, 64'h100);
    check("m0_ready_pulse", {62'd0, m1_ready, m0_ready}, 64'd1);
    check("m0_rdata", {32'd0, m0_rdata}, 64'hDEADBEEF);
    cyc();
    man_ready = 1'b0; man_rdata = '0; m_valid[0] = 1'b0;
    @(negedge clk);
    check("drain_s_valid", {63'd0, s_valid}, 64'd0);
    check("drain_no_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
    repeat (2) cyc();

    // Spurious s_ready in IDLE
    man_ready = 1'b1; man_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("spur_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
    check("spur_rdata", {m1_rdata, m0_rdata}, 64'd0);
    cyc();
    man_ready = 1'b0; man_rdata = '0;
    @(negedge clk);
    check("spur_s_valid", {63'd0, s_valid}, 64'd0);

    // Reset during BUSY
    cyc();
    cur[0] = rand_req();
    m_valid[0] = 1'b1;
    repeat (2) cyc();
    rst = 1'b1; m_valid[0] = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy_s_valid", {63'd0, s_valid}, 64'd0);
    check("rst_busy_ready", {62'd0, m1_ready, m0_ready}, 64'd0);
    cyc();

    // Random traffic; both masters start in the same cycle, m0 must win first
    grant_log.delete();
    slave_en = 1'b1;
    fork
      master(0, 24);
      master(1, 20);
    join
    slave_en = 1'b0;
    repeat (4) cyc();
    for (int i = 0; i < 16 && i < grant_log.size(); i++) begin
      check("alternation", grant_log[i], i % 2);
    end
    check("grant_count", grant_log.size(), 44);
    check("queues_empty", grant_q.size() + rdata_q.size(), 0);

`ifdef QQSPI_ARB_PERF_EN
    @(negedge clk);
    check("perf_m0", {32'd0, perf_m0_cnt}, exp_cnt[0]);
    check("perf_m1", {32'd0, perf_m1_cnt}, exp_cnt[1]);
    check("perf_wait", {32'd0, perf_wait_cnt}, exp_wait);
`endif

    // perf_clr together with a completing s_ready: clear must win
    cyc();
    cur[0] = rand_req();
    m_valid[0] = 1'b1;
    t = 0;
    do begin
      cyc();
      t++;
    end while (!s_valid && t < 20);
    check("clr_grant", {63'd0, s_valid}, 64'd1);
    man_ready = 1'b1; man_rdata = $urandom; perf_clr = 1'b1;
    rdata_q.push_back(man_rdata);
    cyc();
    man_ready = 1'b0; perf_clr = 1'b0; m_valid[0] = 1'b0;
    @(negedge clk);
    check("clr_m0", {32'd0, perf_m0_cnt}, 64'd0);
    check("clr_m1_wait", {perf_m1_cnt, perf_wait_cnt}, 64'd0);
`ifdef QQSPI_ARB_PERF_EN
    check("clr_model", {32'd0, perf_m0_cnt}, exp_cnt[0]);
`endif
    repeat (2) cyc();
    check("final_queues", grant_q.size() + rdata_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
